// File: rtl/bcd_seq_converter.sv
// Binary-to-BCD converter: shift-and-add-3 (double dabble), one operand bit per clock.
// Latency: WIDTH cycles from the accept edge to out_valid; throughput 1 result per WIDTH+2 cycles.
// Backpressure: out_valid/out_bcd hold until out_ready; in_ready stays low in SHIFT and DONE.
// Optional feature: define BCD_CONV_NDIGITS_EN to add out_ndigits (significant digit count).
module bcd_seq_converter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
`ifdef BCD_CONV_NDIGITS_EN
    output logic [$clog2(DIGITS+1)-1:0] out_ndigits,
`endif
    output logic                  busy
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [WIDTH-1:0] r_shift;
    logic [SW-1:0]    r_scratch;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_out_bcd;
    logic             r_out_valid;

    logic [SW-1:0]    w_adj;
    logic [SW-1:0]    w_scr_nxt;
    logic [WIDTH-1:0] w_shf_nxt;
    logic             w_accept;
    logic             w_last;
    logic             w_release;

    // State register; reset abandons any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)             w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_count == LAST_CNT)  w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)            w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs and datapath strobes; in_ready depends on state only
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        w_last    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
            end
            S_SHIFT: begin
                busy   = 1'b1;
                w_last = (r_count == LAST_CNT);
            end
            S_DONE: begin
                busy      = 1'b1;
                w_release = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Add-3 correction per nibble, no carry between digits; DIGITS is sized so
    // the top nibble never exceeds 4 before correction and cannot overflow.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // One double-dabble step: shift {corrected scratch, operand} left by one
    always_comb begin
        w_scr_nxt = {w_adj[SW-2:0], r_shift[WIDTH-1]};
        w_shf_nxt = r_shift << 1;
    end

    // Working registers: loaded on accept, stepped every SHIFT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_shift   <= in_bin;
            r_scratch <= '0;
            r_count   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_shift   <= w_shf_nxt;
            r_scratch <= w_scr_nxt;
            r_count   <= r_count + CW'(1);
        end
    end

    // Result register: captured on the final shift, kept after the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_bcd <= '0;
        end else if (w_last) begin
            r_out_bcd <= w_scr_nxt;
        end
    end

    // Result valid: raised with the result, dropped by the consumer handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_bcd   = r_out_bcd;

`ifdef BCD_CONV_NDIGITS_EN
    localparam int NDW = $clog2(DIGITS + 1);

    logic [NDW-1:0] r_ndigits;
    logic [NDW-1:0] w_ndigits;

    // Position of the most significant nonzero digit plus one; zero counts as one digit
    always_comb begin
        w_ndigits = NDW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (w_scr_nxt[4*i +: 4] != 4'd0) begin
                w_ndigits = NDW'(i + 1);
            end
        end
    end

    // Digit count registered alongside the result it describes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ndigits <= '0;
        end else if (w_last) begin
            r_ndigits <= w_ndigits;
        end
    end

    assign out_ndigits = r_ndigits;
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: decimal reference model plus per-cycle compare.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Directed scenarios cover latency, backpressure, ignored input, mid-run reset, random traffic.
module tb_bcd_seq_converter;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;
    localparam int PERIOD = WIDTH + 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_bin    = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [39:0] out_bcd;
`ifdef BCD_CONV_NDIGITS_EN
    logic [3:0]  out_ndigits;
`endif

    bcd_seq_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bin     (in_bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bcd    (out_bcd),
`ifdef BCD_CONV_NDIGITS_EN
        .out_ndigits(out_ndigits),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Model: one operand in flight, result visible WIDTH edges after acceptance
    int          cyc     = 0;
    bit          m_pend  = 1'b0;
    int          m_done  = 0;
    logic [39:0] m_val   = '0;
    logic [39:0] m_last  = '0;
    int          m_vnd   = 0;
    int          m_nd    = 0;
    bit          rand_rdy = 1'b0;

    function automatic logic [39:0] ref_bcd(input logic [31:0] b);
        longint unsigned v = 64'(b);
        logic [39:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int ref_nd(input logic [31:0] b);
        longint unsigned v = 64'(b);
        int n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        cyc++;
        if (m_pend && cyc > m_done && out_ready) begin
            m_pend = 1'b0;
        end else if (m_pend && cyc == m_done) begin
            m_last = m_val;
            m_nd   = m_vnd;
        end else if (!m_pend && in_valid) begin
            m_pend = 1'b1;
            m_done = cyc + WIDTH;
            m_val  = ref_bcd(in_bin);
            m_vnd  = ref_nd(in_bin);
        end
    endtask

    task automatic compare();
        bit ok = 1'b1;
        chk("in_ready",  64'(in_ready),  64'(!m_pend));
        chk("out_valid", 64'(out_valid), 64'(m_pend && cyc >= m_done));
        chk("busy",      64'(busy),      64'(m_pend));
        chk("out_bcd",   64'(out_bcd),   64'(m_last));
        for (int i = 0; i < DIGITS; i++) begin
            if (out_bcd[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        chk("digit_range", 64'(ok), 64'(1));
`ifdef BCD_CONV_NDIGITS_EN
        chk("out_ndigits", 64'(out_ndigits), 64'(m_nd));
`endif
    endtask

    task automatic tick();
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        if (rst_n) compare();
    endtask

    task automatic send(input logic [31:0] b);
        bit free;
        bit done = 1'b0;
        int k = 0;
        in_valid = 1'b1;
        in_bin   = b;
        while (!done && k < 200) begin
            free = !m_pend;
            tick();
            if (free) done = 1'b1;
            k++;
        end
        chk("accept_timeout", 64'(done), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        int k = 0;
        while (out_valid !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        chk("valid_timeout", 64'(out_valid), 64'(1));
    endtask

    initial begin
        int          rises;
        int          k;
        int          first;
        int          second;
        bit          prev;
        logic [31:0] b;

        // Hand-computed values pinning the reference model
        chk("model_zero",  64'(ref_bcd(32'd0)),          64'h0);
        chk("model_max",   64'(ref_bcd(32'hFFFFFFFF)),   64'h4294967295);
        chk("model_mixed", 64'(ref_bcd(32'd1234567890)), 64'h1234567890);
        chk("model_nd0",   64'(ref_nd(32'd0)),           64'd1);
        chk("model_ndmax", 64'(ref_nd(32'hFFFFFFFF)),    64'd10);
        chk("model_nd42",  64'(ref_nd(32'd42)),          64'd2);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_out_bcd",   64'(out_bcd),   64'h0);
        rst_n = 1'b1;
        tick();

        // 1: zero operand, exact latency
        out_ready = 1'b1;
        send(32'd0);
        repeat (WIDTH - 1) tick();
        chk("t1_not_early", 64'(out_valid), 64'(0));
        tick();
        chk("t1_latency", 64'(out_valid), 64'(1));
        chk("t1_bcd",     64'(out_bcd),   64'h0);
`ifdef BCD_CONV_NDIGITS_EN
        chk("t1_ndigits", 64'(out_ndigits), 64'd1);
`endif
        tick();
        chk("t1_release", 64'(in_ready), 64'(1));

        // 2: all ones
        send(32'hFFFFFFFF);
        wait_valid(40);
        chk("t2_bcd", 64'(out_bcd), 64'h4294967295);
`ifdef BCD_CONV_NDIGITS_EN
        chk("t2_ndigits", 64'(out_ndigits), 64'd10);
`endif
        tick();

        // 3: consumer stalls for 5 cycles
        out_ready = 1'b0;
        send(32'd1234567890);
        wait_valid(40);
        repeat (5) begin
            tick();
            chk("t3_hold_valid", 64'(out_valid), 64'(1));
            chk("t3_hold_bcd",   64'(out_bcd),   64'h1234567890);
        end
        chk("t3_no_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        tick();
        chk("t3_drop",     64'(out_valid), 64'(0));
        chk("t3_in_ready", 64'(in_ready),  64'(1));
        chk("t3_keep_bcd", 64'(out_bcd),   64'h1234567890);

        // 4: stray in_valid during SHIFT is ignored
        send(32'd555);
        repeat (3) tick();
        in_valid = 1'b1;
        in_bin   = 32'd7;
        tick();
        in_valid = 1'b0;
        wait_valid(40);
        chk("t4_bcd", 64'(out_bcd), 64'h555);
        tick();
        rises = 0;
        repeat (40) begin
            tick();
            if (out_valid) rises++;
        end
        chk("t4_no_second", 64'(rises), 64'(0));

        // 5: reset in the middle of a conversion
        send(32'd99999);
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_in_ready",  64'(in_ready),  64'(1));
        chk("t5_out_valid", 64'(out_valid), 64'(0));
        chk("t5_busy",      64'(busy),      64'(0));
        chk("t5_out_bcd",   64'(out_bcd),   64'h0);
`ifdef BCD_CONV_NDIGITS_EN
        chk("t5_ndigits",   64'(out_ndigits), 64'd0);
`endif
        m_pend = 1'b0;
        m_last = '0;
        m_nd   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        repeat (40) begin
            tick();
            if (out_valid) rises++;
        end
        chk("t5_no_valid", 64'(rises), 64'(0));
        send(32'd42);
        wait_valid(40);
        chk("t5_bcd42", 64'(out_bcd), 64'h42);
        tick();

        // 6: back-to-back random operands, random consumer readiness
        rand_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9999));
            else                           b = $urandom();
            send(b);
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (m_pend && k < 60) begin
            tick();
            k++;
        end
        chk("t6_drain", 64'(m_pend), 64'(0));

        // Throughput with in_valid and out_ready held high
        in_valid = 1'b1;
        in_bin   = 32'd123;
        first    = -1;
        second   = -1;
        prev     = out_valid;
        for (int t = 0; t < 120; t++) begin
            tick();
            if (out_valid && !prev) begin
                if (first < 0)       first  = t;
                else if (second < 0) second = t;
            end
            prev = out_valid;
        end
        in_valid = 1'b0;
        chk("throughput", 64'(second - first), 64'(PERIOD));
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
